// File: rtl/m_axil_fsb_pkg.sv
// m_axil_fsb_pkg: shared types and constants for the FSB -> AXI-Lite ring writer.
//   state_t     : top-level FSM states
//   fsb_pkt_t   : one 80-bit FSB packet
//   build_slot  : packs a packet plus sequence byte into the 128-bit ring slot image
package m_axil_fsb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        NEXT  = 2'd3
    } state_t;

    typedef logic [79:0] fsb_pkt_t;

    localparam int unsigned SLOT_BYTES     = 16;
    localparam int unsigned WORDS_PER_SLOT = 4;
    localparam logic [15:0] MAGIC          = 16'hFB5A;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

    // Word 3 (top 32 bits) carries magic + sequence so the host can treat it as the
    // slot-valid marker; it is also the last word written.
    function automatic logic [127:0] build_slot(input fsb_pkt_t pkt, input logic [7:0] seq);
        return {MAGIC, 8'h00, seq, 16'h0000, pkt[79:64], pkt[63:32], pkt[31:0]};
    endfunction

endpackage

// File: rtl/m_axil_fsb_beat_issuer.sv
// m_axil_fsb_beat_issuer: drives one AXI-Lite write (AW + W) per start pulse.
//   clk, rst       : clock, asynchronous active-high reset
//   start_i        : load addr_i/data_i and raise both valids next cycle
//   addr_i, data_i : payload for the beat being started
//   m_axi_aw*/w*   : AW and W channels; each valid drops on its own handshake
//   issue_done_o   : high in the cycle the last outstanding handshake completes
module m_axil_fsb_beat_issuer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    output logic        issue_done_o
);

    logic        aw_pend_q, aw_pend_d;
    logic        w_pend_q,  w_pend_d;
    logic [31:0] awaddr_q,  awaddr_d;
    logic [31:0] wdata_q,   wdata_d;

    // Next-state for the two independent channel-pending flags and payload holds
    always_comb begin
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        if (start_i) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            awaddr_d  = addr_i;
            wdata_d   = data_i;
        end else begin
            if (aw_pend_q && m_axi_awready) begin
                aw_pend_d = 1'b0;
            end else begin
                aw_pend_d = aw_pend_q;
            end
            if (w_pend_q && m_axi_wready) begin
                w_pend_d = 1'b0;
            end else begin
                w_pend_d = w_pend_q;
            end
        end
    end

    // Channel flags and payload registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            awaddr_q  <= 32'h0000_0000;
            wdata_q   <= 32'h0000_0000;
        end else begin
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = aw_pend_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = w_pend_q;

    // Complete when every channel still pending handshakes this cycle
    assign issue_done_o = (aw_pend_q | w_pend_q) &
                          (~aw_pend_q | m_axi_awready) &
                          (~w_pend_q  | m_axi_wready);

endmodule

// File: rtl/m_axil_fsb_master.sv
// m_axil_fsb_master: writes each accepted 80-bit FSB packet as four 32-bit AXI-Lite
// writes into a host ring of RING_PKTS 16-byte slots starting at BASE_ADDR.
//   clk_main_a0, rst_main      : clock, asynchronous active-high reset
//   fsb_v_i/fsb_data_i/ready_o : packet input, accepted only in IDLE
//   m_axi_aw*/w*/b*            : AXI-Lite write master, one write outstanding
//   wr_ptr_o                   : next ring slot to be written
//   pkt_cnt_o                  : packets fully written (wraps at 2^32)
//   err_cnt_o                  : non-OKAY responses (saturating)
// Optional: define M_AXIL_FSB_TIMEOUT_EN to give up on a missing B response after
// TIMEOUT_CYC cycles in RESP (counted as an error).
module m_axil_fsb_master
    import m_axil_fsb_pkg::*;
#(
    parameter int unsigned FSB_WIDTH   = 80,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned RING_PKTS   = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                         clk_main_a0,
    input  logic                         rst_main,
    input  logic                         fsb_v_i,
    input  logic [FSB_WIDTH-1:0]         fsb_data_i,
    output logic                         fsb_ready_o,
    output logic [31:0]                  m_axi_awaddr,
    output logic                         m_axi_awvalid,
    input  logic                         m_axi_awready,
    output logic [31:0]                  m_axi_wdata,
    output logic [3:0]                   m_axi_wstrb,
    output logic                         m_axi_wvalid,
    input  logic                         m_axi_wready,
    input  logic [1:0]                   m_axi_bresp,
    input  logic                         m_axi_bvalid,
    output logic                         m_axi_bready,
    output logic [$clog2(RING_PKTS)-1:0] wr_ptr_o,
    output logic [31:0]                  pkt_cnt_o,
    output logic [15:0]                  err_cnt_o
);

    localparam int unsigned PW = $clog2(RING_PKTS);

    if (FSB_WIDTH != 80) begin : g_bad_width
        $error("m_axil_fsb_master: FSB_WIDTH must be 80");
    end
    if (BASE_ADDR[3:0] != 4'h0) begin : g_bad_base
        $error("m_axil_fsb_master: BASE_ADDR must be 16-byte aligned");
    end
    if (RING_PKTS < 2 || RING_PKTS > 256 || (RING_PKTS & (RING_PKTS - 1)) != 0) begin : g_bad_ring
        $error("m_axil_fsb_master: RING_PKTS must be a power of two in 2..256");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_tmo
        $error("m_axil_fsb_master: TIMEOUT_CYC must be at least 1");
    end

    state_t          state_q, state_d;
    logic [1:0]      beat_q, beat_d;
    logic [127:0]    slot_q, slot_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]     pkt_cnt_q, pkt_cnt_d;
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic            ready_q, ready_d;
    logic            bready_q, bready_d;
    logic            start_s;
    logic            issue_done_s;
    logic            beat_end_s;
    logic            err_inc_s;
    logic [31:0]     beat_addr_s;
    logic [31:0]     beat_word_s;
`ifdef M_AXIL_FSB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            tmo_fire_s;
`endif

    // FSM next-state, slot capture, counters and beat launch
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        slot_d     = slot_q;
        wr_ptr_d   = wr_ptr_q;
        pkt_cnt_d  = pkt_cnt_q;
        err_cnt_d  = err_cnt_q;
        start_s    = 1'b0;
        beat_end_s = 1'b0;
        err_inc_s  = 1'b0;
`ifdef M_AXIL_FSB_TIMEOUT_EN
        tmo_d      = '0;
        // bvalid in the same cycle wins over the timeout
        tmo_fire_s = (state_q == RESP) && !m_axi_bvalid && (tmo_q == TW'(TIMEOUT_CYC - 1));
`endif
        case (state_q)
            IDLE: begin
                if (fsb_v_i && ready_q) begin
                    slot_d  = build_slot(fsb_data_i, pkt_cnt_q[7:0]);
                    beat_d  = 2'd0;
                    start_s = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (issue_done_s) begin
                    state_d = RESP;
                end else begin
                    state_d = ISSUE;
                end
            end
            RESP: begin
                if (m_axi_bvalid && bready_q) begin
                    beat_end_s = 1'b1;
                    err_inc_s  = (m_axi_bresp != AXI_RESP_OKAY);
`ifdef M_AXIL_FSB_TIMEOUT_EN
                end else if (tmo_fire_s) begin
                    beat_end_s = 1'b1;
                    err_inc_s  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
`else
                end else begin
                    beat_end_s = 1'b0;
`endif
                end
                if (beat_end_s) begin
                    if (beat_q == 2'(WORDS_PER_SLOT - 1)) begin
                        state_d = NEXT;
                    end else begin
                        beat_d  = beat_q + 2'd1;
                        start_s = 1'b1;
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = RESP;
                end
            end
            NEXT: begin
                wr_ptr_d  = wr_ptr_q + PW'(1);
                pkt_cnt_d = pkt_cnt_q + 32'd1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (err_inc_s && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end

        ready_d     = (state_d == IDLE);
        bready_d    = (state_d == RESP);
        beat_addr_s = BASE_ADDR + 32'(wr_ptr_q) * 32'(SLOT_BYTES) + 32'(beat_d) * 32'd4;
        beat_word_s = slot_d[{beat_d, 5'b00000} +: 32];
    end

    // FSM state, slot image, counters and registered handshake outputs
    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            state_q   <= IDLE;
            beat_q    <= 2'd0;
            slot_q    <= 128'd0;
            wr_ptr_q  <= '0;
            pkt_cnt_q <= 32'd0;
            err_cnt_q <= 16'd0;
            ready_q   <= 1'b0;
            bready_q  <= 1'b0;
`ifdef M_AXIL_FSB_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            slot_q    <= slot_d;
            wr_ptr_q  <= wr_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
            ready_q   <= ready_d;
            bready_q  <= bready_d;
`ifdef M_AXIL_FSB_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    m_axil_fsb_beat_issuer u_issuer (
        .clk           (clk_main_a0),
        .rst           (rst_main),
        .start_i       (start_s),
        .addr_i        (beat_addr_s),
        .data_i        (beat_word_s),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .issue_done_o  (issue_done_s)
    );

    assign fsb_ready_o  = ready_q;
    assign m_axi_bready = bready_q;
    assign wr_ptr_o     = wr_ptr_q;
    assign pkt_cnt_o    = pkt_cnt_q;
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_m_axil_fsb_master.sv
// Testbench for m_axil_fsb_master: a behavioural AXI-Lite slave with configurable or
// random delays logs completed writes; a ring model predicts every write from the
// packet contents, slot index and sequence number.
module tb_m_axil_fsb_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        fsb_v;
    logic [79:0] fsb_data;
    logic        fsb_ready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  wr_ptr;
    logic [31:0] pkt_cnt;
    logic [15:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    // slave configuration
    bit rand_mode = 1'b0;
    int cfg_aw = 0, cfg_w = 0, cfg_b = 0;
    int err_beat = -1;

    // slave state
    bit aw_got, w_got, aw_seen, w_seen, b_started, b_hs;
    int aw_wait, w_wait, b_wait;
    logic [31:0] aw_first, w_first, aw_l, w_l;
    int viol = 0;
    int exp_err = 0;
    logic [31:0] log_addr[$], log_data[$];

    // reference model
    int m_pkt = 0;
    logic [31:0] exp_addr[$], exp_data[$];

    m_axil_fsb_master dut (
        .clk_main_a0   (clk),
        .rst_main      (rst),
        .fsb_v_i       (fsb_v),
        .fsb_data_i    (fsb_data),
        .fsb_ready_o   (fsb_ready),
        .m_axi_awaddr  (awaddr),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .wr_ptr_o      (wr_ptr),
        .pkt_cnt_o     (pkt_cnt),
        .err_cnt_o     (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic int pick(input int cfg);
        return rand_mode ? int'($urandom_range(0, 3)) : cfg;
    endfunction

    // AXI-Lite slave: decides readies/bvalid at negedge for the upcoming posedge
    always @(negedge clk) begin
        if (rst) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
            aw_got = 0; w_got = 0; aw_seen = 0; w_seen = 0; b_started = 0; b_hs = 0;
            exp_err = 0;
            log_addr.delete(); log_data.delete();
        end else begin
            if (b_hs) begin
                bvalid = 1'b0; b_hs = 0;
            end
            // B only after both AW and W handshakes have actually completed
            if (aw_got && w_got && !bvalid) begin
                if (!b_started) begin b_wait = pick(cfg_b); b_started = 1; end
                if (b_wait > 0) b_wait--;
                else begin
                    bvalid = 1'b1;
                    if (rand_mode) bresp = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00;
                    else bresp = (err_beat >= 0 && aw_l[3:2] == err_beat[1:0]) ? 2'b10 : 2'b00;
                end
            end
            if (bvalid && bready && !b_hs) begin
                b_hs = 1;
                log_addr.push_back(aw_l); log_data.push_back(w_l);
                if (bresp != 2'b00) exp_err++;
                aw_got = 0; w_got = 0; aw_seen = 0; w_seen = 0; b_started = 0;
            end
            awready = 1'b0;
            if (awvalid) begin
                if (aw_got) viol++;
                else begin
                    if (!aw_seen) begin aw_seen = 1; aw_first = awaddr; aw_wait = pick(cfg_aw); end
                    else if (awaddr !== aw_first) viol++;
                    if (aw_wait > 0) aw_wait--;
                    else begin awready = 1'b1; aw_got = 1; aw_l = awaddr; end
                end
            end
            wready = 1'b0;
            if (wvalid) begin
                if (w_got || wstrb !== 4'hF) viol++;
                else begin
                    if (!w_seen) begin w_seen = 1; w_first = wdata; w_wait = pick(cfg_w); end
                    else if (wdata !== w_first) viol++;
                    if (w_wait > 0) w_wait--;
                    else begin wready = 1'b1; w_got = 1; w_l = wdata; end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; fsb_v = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        exp_addr.delete(); exp_data.delete();
        m_pkt = 0; viol = 0;
        @(negedge clk);
    endtask

    // ring model: four words per slot, slot index and sequence from packet number
    task automatic push_exp(input logic [79:0] d);
        logic [31:0] base;
        logic [7:0]  seq;
        base = 32'h0000_1000 + 32'((m_pkt % 16) * 16);
        seq  = 8'(m_pkt);
        exp_addr.push_back(base);          exp_data.push_back(d[31:0]);
        exp_addr.push_back(base + 32'd4);  exp_data.push_back(d[63:32]);
        exp_addr.push_back(base + 32'd8);  exp_data.push_back({16'h0000, d[79:64]});
        exp_addr.push_back(base + 32'd12); exp_data.push_back({16'hFB5A, 8'h00, seq});
        m_pkt++;
    endtask

    task automatic send_pkt(input logic [79:0] d);
        int n = 0;
        while (!fsb_ready && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (!fsb_ready) begin
            failures++;
            $display("FAIL send_ready got=%0b exp=1", fsb_ready);
        end else begin
            fsb_v = 1'b1; fsb_data = d;
            push_exp(d);
            @(negedge clk);
            fsb_v = 1'b0;
        end
    endtask

    task automatic check_writes(input string tag);
        int n = 0;
        logic [31:0] a, d, ea, ed;
        while (log_addr.size() < exp_addr.size() && n < 3000) begin @(negedge clk); n++; end
        checks++;
        if (log_addr.size() != exp_addr.size()) begin
            failures++;
            $display("FAIL %s write_count got=%0d exp=%0d", tag, log_addr.size(), exp_addr.size());
        end
        while (exp_addr.size() > 0 && log_addr.size() > 0) begin
            a = log_addr.pop_front(); d = log_data.pop_front();
            ea = exp_addr.pop_front(); ed = exp_data.pop_front();
            checks++;
            if (a !== ea || d !== ed) begin
                failures++;
                $display("FAIL %s write got=%h<-%h exp=%h<-%h", tag, a, d, ea, ed);
            end
        end
        exp_addr.delete(); exp_data.delete();
        n = 0;
        while (!fsb_ready && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (!fsb_ready) begin failures++; $display("FAIL %s ready_return got=0 exp=1", tag); end
        checks++;
        if (viol != 0) begin failures++; $display("FAIL %s protocol_violations got=%0d exp=0", tag, viol); end
    endtask

    task automatic test_reset();
        rst = 1'b1; fsb_v = 1'b0; fsb_data = 80'd0;
        @(negedge clk); @(negedge clk);
        checks++;
        if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0 || fsb_ready !== 1'b0 ||
            wr_ptr !== 4'd0 || pkt_cnt !== 32'd0 || err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_outputs got aw=%b w=%b b=%b rdy=%b ptr=%0d pkt=%0d err=%0d exp all 0",
                     awvalid, wvalid, bready, fsb_ready, wr_ptr, pkt_cnt, err_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (fsb_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", fsb_ready); end
    endtask

    task automatic test_single();
        logic exp_r;
        do_reset();
        rand_mode = 0; cfg_aw = 0; cfg_w = 0; cfg_b = 0; err_beat = -1;
        send_pkt(80'h1234_89AB_CDEF_0011_2233);
        // now in cycle 1 after accept; ready must return exactly on cycle 10
        for (int k = 1; k <= 10; k++) begin
            exp_r = (k == 10);
            checks++;
            if (fsb_ready !== exp_r) begin
                failures++;
                $display("FAIL single_ready_cycle%0d got=%b exp=%b", k, fsb_ready, exp_r);
            end
            if (k < 10) @(negedge clk);
        end
        checks++;
        if (pkt_cnt !== 32'd1 || wr_ptr !== 4'd1) begin
            failures++;
            $display("FAIL single_counters got pkt=%0d ptr=%0d exp pkt=1 ptr=1", pkt_cnt, wr_ptr);
        end
        check_writes("single");
    endtask

    task automatic test_skew();
        do_reset();
        rand_mode = 0; cfg_b = 0; err_beat = -1;
        cfg_aw = 3; cfg_w = 0;
        send_pkt({$urandom, $urandom, $urandom});
        check_writes("skew_aw");
        cfg_aw = 0; cfg_w = 3;
        send_pkt({$urandom, $urandom, $urandom});
        check_writes("skew_w");
        cfg_w = 0;
    endtask

    task automatic test_error();
        do_reset();
        rand_mode = 0; cfg_aw = 0; cfg_w = 0; cfg_b = 1; err_beat = 1;
        send_pkt({$urandom, $urandom, $urandom});
        check_writes("error");
        checks++;
        if (err_cnt !== 16'd1 || pkt_cnt !== 32'd1) begin
            failures++;
            $display("FAIL error_counts got err=%0d pkt=%0d exp err=1 pkt=1", err_cnt, pkt_cnt);
        end
        err_beat = -1; cfg_b = 0;
    endtask

    task automatic test_back_to_back_wrap();
        do_reset();
        rand_mode = 1; err_beat = -1;
        for (int i = 0; i < 17; i++) send_pkt({$urandom, $urandom, $urandom});
        check_writes("wrap");
        checks++;
        if (wr_ptr !== 4'd1 || pkt_cnt !== 32'd17 || err_cnt !== 16'(exp_err)) begin
            failures++;
            $display("FAIL wrap_counters got ptr=%0d pkt=%0d err=%0d exp ptr=1 pkt=17 err=%0d",
                     wr_ptr, pkt_cnt, err_cnt, exp_err);
        end
        rand_mode = 0;
    endtask

    task automatic test_mid_reset();
        int n = 0;
        do_reset();
        rand_mode = 0; cfg_aw = 0; cfg_w = 0; cfg_b = 6; err_beat = -1;
        send_pkt({$urandom, $urandom, $urandom});
        while (log_addr.size() < 2 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk); @(negedge clk); @(negedge clk);
        checks++;
        if (bready !== 1'b1 || log_addr.size() != 2) begin
            failures++;
            $display("FAIL midrst_in_resp got bready=%b writes=%0d exp bready=1 writes=2",
                     bready, log_addr.size());
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0 || fsb_ready !== 1'b0 ||
            wr_ptr !== 4'd0 || pkt_cnt !== 32'd0 || err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL midrst_clear got aw=%b w=%b b=%b rdy=%b ptr=%0d pkt=%0d err=%0d exp all 0",
                     awvalid, wvalid, bready, fsb_ready, wr_ptr, pkt_cnt, err_cnt);
        end
        cfg_b = 0;
        do_reset();
        send_pkt(80'hA5A5_0102_0304_0506_0708);
        check_writes("midrst_after");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_skew();
        test_error();
        test_back_to_back_wrap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/m_axil_fsb_master.md
Name: m_axil_fsb_master

Overview:
- Outbound counterpart of the OCL AXI-Lite slave adapter. That adapter receives host accesses and turns them into FSB traffic; this block takes FSB packets from the fabric and turns them into AXI-Lite master writes toward the host.
- Each 80-bit FSB packet is written as four 32-bit words into a host-visible ring of RING_PKTS 16-byte slots.
- Instantiated in cl_fsb on clk_main_a0, between the FSB egress FIFO and the outbound AXI-Lite register slice.

Parameters:
- FSB_WIDTH, 80, FSB packet width; fixed to 80, other values rejected at elaboration.
- BASE_ADDR, 32'h0000_1000, byte address of ring slot 0; must be 16-byte aligned.
- RING_PKTS, 16, number of ring slots; power of two, 2..256.
- TIMEOUT_CYC, 1024, B-channel timeout in cycles; used only with the optional feature.

Ports:
- clk_main_a0  in  1  clock
- rst_main  in  1  reset, asynchronous, active-high
- fsb_v_i  in  1  packet valid
- fsb_data_i  in  80  packet
- fsb_ready_o  out  1  packet accepted when fsb_v_i & fsb_ready_o
- m_axi_awaddr  out  32  write address
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  32
- m_axi_wstrb  out  4
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1
- wr_ptr_o  out  $clog2(RING_PKTS)  next slot to be written
- pkt_cnt_o  out  32  packets fully written
- err_cnt_o  out  16  non-OKAY responses, saturating

Behaviour:
- Reset: asynchronous assert; all state clears immediately. Outputs after reset: fsb_ready_o=0, awvalid=0, wvalid=0, bready=0, wr_ptr_o=0, pkt_cnt_o=0, err_cnt_o=0, state=IDLE. Mid-transaction reset abandons the packet; no replay.
- FSM states: IDLE, ISSUE, RESP, NEXT.
- IDLE
  - fsb_ready_o=1.
  - On accept: capture the packet into a 128-bit slot register, beat=0, go to ISSUE. Accept occurs only in IDLE, so there is no input skid.
- Slot layout:
  - word0 = data[31:0]
  - word1 = data[63:32]
  - word2 = {16'h0, data[79:64]}
  - word3 = {16'hFB5A, 8'h0, seq[7:0]}, where seq = pkt_cnt_o[7:0] at capture
- ISSUE
  - awvalid and wvalid assert in the same cycle. awaddr = BASE_ADDR + (wr_ptr<<4) + (beat<<2); wdata = word[beat]; wstrb = 4'hF.
  - Each valid drops independently on its own handshake; AW and W may complete in either order or together.
  - Valid and payload stay stable until handshake.
  - When both handshakes are done, go to RESP.
- RESP
  - bready=1.
  - On bvalid: if bresp != 2'b00, err_cnt_o increments, saturating at 16'hFFFF.
  - If beat==3, go to NEXT; otherwise beat++ and return to ISSUE.
  - Exactly one write is outstanding at a time. A response with an error does not retry.
- NEXT: wr_ptr increments modulo RING_PKTS (RING_PKTS-1 wraps to 0), pkt_cnt_o increments with 32-bit wrap, go to IDLE.
- Timing:
  - Minimum packet period is 10 cycles: 1 accept, then 4×(ISSUE+RESP) with zero-wait slaves, then 1 NEXT.
  - Word 3 is always written last, so a host can use the seq/magic word as the "slot valid" marker.

Optional Feature:
- Macro: M_AXIL_FSB_TIMEOUT_EN.
- Defined:
  - A counter runs in RESP, clearing whenever RESP is entered.
  - If it reaches TIMEOUT_CYC without bvalid: err_cnt_o increments, the beat is treated as complete, and the FSM proceeds as if bvalid had arrived.
  - A bvalid arriving in the same cycle as the timeout takes priority: the counter does not fire and the response is processed normally.
- Undefined: no counter; the FSM waits in RESP indefinitely.

Decomposition:
- Package m_axil_fsb_pkg holds:
  - state enum (IDLE, ISSUE, RESP, NEXT)
  - fsb_pkt_t (80-bit packed)
  - localparams: SLOT_BYTES=16, WORDS_PER_SLOT=4, MAGIC=16'hFB5A, AXI_RESP_OKAY=2'b00
- One natural sub-module: m_axil_fsb_beat_issuer. It drives the AW/W channels with independent done flags and reports issue completion.

Test Plan:
1. Single packet 80'h1234_89AB_CDEF_0011_2233, zero-wait slave -> exactly these writes, in order:
   - 0x1000 ← 0x0011_2233
   - 0x1004 ← 0x89AB_CDEF
   - 0x1008 ← 0x0000_1234
   - 0x100C ← 0xFB5A_0000
   
   Afterwards: pkt_cnt_o=1, wr_ptr_o=1, fsb_ready_o high again on cycle 10.
2. AW/W skew: awready delayed 3 cycles, wready immediate (then the reverse) -> one write per beat, stable payload while waiting, no duplicate handshake.
3. Wrap: 17 packets with RING_PKTS=16 -> packet 16 writes 0x1000..0x100C with seq=0x10; wr_ptr_o=1.
4. bresp=2'b10 on beat 1 of packet 0 -> err_cnt_o=1; beats 2–3 still issued; pkt_cnt_o=1.
5. rst_main asserted while in RESP on beat 2 -> all valids low in the same cycle, counters 0; next packet writes at 0x1000.
6. With M_AXIL_FSB_TIMEOUT_EN and TIMEOUT_CYC=8, bvalid withheld -> err_cnt_o increments after 8 RESP cycles and the FSM advances to the next beat.
